// File: rtl/im_ctrl.sv
// rtl/im_ctrl.sv - instruction memory controller: program loader plus single-cycle-latency CPU fetch port
module im_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          ld_done,
  input  logic [31:0]   pc,
  input  logic          fetch_req,
  output logic          fetch_ack,
  output logic [31:0]   instr,
  output logic          stall,
  output logic          fault,
  output logic [AW:0]   word_count,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] cnt;
  logic          load_wr;
  logic          load_end;
  logic          pc_ok;
  logic          fetch_go;
  logic          fetch_bad;

  // ld_start always wins: it suppresses both a load write and a fetch in the same cycle
  assign load_wr   = (state == S_LOAD) && !ld_start && ld_valid;
  assign load_end  = load_wr && (ld_last || (cnt == AW'(DEPTH - 1)));
  assign pc_ok     = pc < 32'(word_count);
  assign fetch_go  = (state == S_RUN) && fetch_req && !ld_start && pc_ok;
  assign fetch_bad = (state == S_RUN) && fetch_req && !ld_start && !pc_ok;

  assign ld_ready  = (state == S_LOAD);
  assign stall     = (state != S_RUN);
  assign fault     = (state == S_FAULT);
  assign mem_we    = load_wr;
  assign mem_wdata = load_wr ? ld_data : 32'd0;
  assign instr     = fetch_ack ? mem_rdata : 32'd0;

  always_comb begin
    mem_addr = '0;
    if (load_wr)
      mem_addr = cnt;
    else if (fetch_go)
      mem_addr = pc[AW-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ld_start) state_nxt = S_LOAD;
      S_LOAD:  if (load_end) state_nxt = S_RUN;
      S_RUN: begin
        if (ld_start)       state_nxt = S_LOAD;
        else if (fetch_bad) state_nxt = S_FAULT;
      end
      S_FAULT: if (ld_start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      word_count <= '0;
      ld_done    <= 1'b0;
      fetch_ack  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ld_done   <= load_end;
      fetch_ack <= fetch_go;
      if (ld_start)
        cnt <= '0;
      else if (load_wr)
        cnt <= cnt + 1'b1;
      if (load_end)
        word_count <= {1'b0, cnt} + (AW+1)'(1);
    end
  end

endmodule
